fpnew_share_arbiter: RTL
========================

# fpnew_share_arbiter

Shares one `fpnew_top` instance among `NumReq` independent requesters, such as harts or accelerator lanes. Requests are granted round-robin with a grant lock that keeps a stalled offer stable. The arbiter tags each issued operation with the requester index and routes results back by that tag, so out-of-order completion across opgroups is handled correctly. It sits between the requesters' FP issue stages and the FPU's input and output handshakes.

## Interface
- `NumReq`, default 2: number of requesters, ≥1.
- `Width`, default 64: FPU operand/result width; must equal the FPU's `Features.Width`.
- `MaxOutstanding`, default 4: per-requester in-flight limit, ≥1.
- `IdxWidth`, derived: `max(1, $clog2(NumReq))`; also the FPU `TagType` width.
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `flush_i` in 1: abort all in-flight operations.
- `req_i` in `NumReq` × `fpu_req_t`: per-requester operation (operands, `rnd_mode`, `op`, `op_mod`, `src_fmt`, `dst_fmt`, `int_fmt`, `vectorial_op`).
- `req_valid_i` in `NumReq`: request valid.
- `req_ready_o` out `NumReq`: request accepted.
- `rsp_o` out `fpu_rsp_t`: result and status, broadcast to all requesters.
- `rsp_valid_o` out `NumReq`: one-hot response valid.
- `rsp_ready_i` in `NumReq`: response accepted.
- `fpu_req_o` out `fpu_req_t`: operation to the FPU.
- `fpu_tag_o` out `IdxWidth`: requester index sent to the FPU.
- `fpu_in_valid_o` out 1: FPU input valid.
- `fpu_in_ready_i` in 1: FPU input ready.
- `fpu_rsp_i` in `fpu_rsp_t`: FPU result and status.
- `fpu_tag_i` in `IdxWidth`: returned tag.
- `fpu_out_valid_i` in 1: FPU output valid.
- `fpu_out_ready_o` out 1: FPU output ready.
- `fpu_flush_o` out 1: equals `flush_i`.
- `busy_o` out 1: any operation outstanding.

## Operation
- **Eligibility.** Requester i is eligible when `req_valid_i[i]` is high and `cnt[i] < MaxOutstanding`.
- **Round-robin pointer.** `rr_q` holds the first index to consider. Selection picks the first eligible index at or after `rr_q`, wrapping modulo `NumReq`.
- **Grant lock.** If an offer is made and `fpu_in_ready_i` is 0, `lock_q`=1 and `lock_idx_q`=sel. While locked, the same index is offered regardless of eligibility of others. The lock clears on handshake or flush.
- **Requester contract.** Requesters must hold `req_valid_i` and `req_i` stable until `req_ready_o`.
- **FPU input.** `fpu_in_valid_o` = any eligible (or locked). `fpu_req_o`/`fpu_tag_o` = the selected requester's request and index.
- **Issue.** `req_ready_o[sel]` = `fpu_in_ready_i`; all other bits are 0.
- **On issue handshake:** `rr_q` ← sel+1 (wrapped) and `cnt[sel]`++.
- **Response routing.** `rsp_valid_o[fpu_tag_i]` = `fpu_out_valid_i`. `fpu_out_ready_o` = `rsp_ready_i[fpu_tag_i]`. `rsp_o` = `fpu_rsp_i`.
- **On response handshake:** `cnt[fpu_tag_i]`--.
- **Simultaneous issue and retire, same requester:** `cnt` is unchanged.
- **Tag out of range** (`fpu_tag_i` ≥ `NumReq`): the response is dropped, `fpu_out_ready_o`=1, and an assertion fires.
- **Retire at `cnt`=0:** `cnt` stays 0 and an assertion fires.
- **Flush:** in the same cycle, `req_ready_o`=0 and `fpu_in_valid_o`=0. Next cycle, all `cnt`=0 and `lock_q`=0. `rr_q` is kept.
- `busy_o` = OR of all `cnt` ≠ 0.

## Timing
- Reset values: `rr_q`=0, `lock_q`=0, `lock_idx_q`=0, all `cnt`=0.
- After reset, all outputs are 0 until inputs are valid, since outputs are combinational from inputs.
- Request and response paths have zero added latency (combinational pass-through). State updates on the next edge.
- Reset asserted mid-operation clears state immediately. Outstanding FPU results are the FPU's own reset responsibility.
- `cnt` width is `$clog2(MaxOutstanding+1)`; it never exceeds `MaxOutstanding` because of eligibility gating.

## Configuration
- `FPNEW_SHARE_CREDIT_EN` defined: per-requester `cnt` and the `MaxOutstanding` gating are built as described.
- `FPNEW_SHARE_CREDIT_EN` undefined:
  - no counters are built; eligibility = `req_valid_i` only;
  - `busy_o` = a single global in-flight counter ≠ 0, sized `$clog2(NumReq*MaxOutstanding+1)`;
  - underflow assertions still apply to the global counter.

## Structure
- `fpu_req_t` and `fpu_rsp_t` live in `fpnew_pkg`, built from `operation_e`, `roundmode_e`, `fp_format_e`, `int_format_e` and `status_t`. `Width` is exposed as a package localparam for the default config.
- One sub-module: `fpnew_share_rr_sel`. It is a combinational rotate-priority selector with inputs eligible mask and `rr_q`, and outputs sel and any.

## Test plan
- **Round-robin under contention.** `NumReq`=2, both valid, FPU always ready → grants alternate 0,1,0,1; each `cnt` rises by 1 per grant.
- **Grant lock.** Req1 offered while `fpu_in_ready_i`=0 for 3 cycles, req0 raises valid meanwhile → `fpu_tag_o` stays 1 until handshake; req0 is granted next.
- **Credit limit.** `MaxOutstanding`=4, req0 issues 4 with no responses → 5th stalls (`req_ready_o[0]`=0) while req1 still issues. One tag-0 response → req0 issues next cycle.
- **Out-of-order return.** FPU returns tag 1 then tag 0 → `rsp_valid_o` = 2'b10 then 2'b01. `rsp_ready_i[1]`=0 back-pressures `fpu_out_ready_o`.
- **Same-cycle issue and retire.** Req0 issue and req0 response in one cycle → `cnt[0]` unchanged.
- **Flush.** Flush with `cnt`={3,2} and lock set → next cycle `cnt`={0,0}, `lock_q`=0, `busy_o`=0, `fpu_flush_o` pulsed.

Source files
------------

// File: rtl/fpnew_pkg.sv
// Operation and result payload types shared by the FPU and its sharing arbiter.
package fpnew_pkg;

    localparam int unsigned Width       = 64;
    localparam int unsigned NumOperands = 3;

    typedef enum logic [3:0] {
        FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX,
        CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
    } operation_e;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100,
        ROD = 3'b101,
        DYN = 3'b111
    } roundmode_e;

    typedef enum logic [2:0] {
        FP32, FP64, FP16, FP8, FP16ALT
    } fp_format_e;

    typedef enum logic [1:0] {
        INT8, INT16, INT32, INT64
    } int_format_e;

    typedef struct packed {
        logic NV;
        logic DZ;
        logic OF;
        logic UF;
        logic NX;
    } status_t;

    typedef struct packed {
        logic [NumOperands-1:0][Width-1:0] operands;
        roundmode_e                        rnd_mode;
        operation_e                        op;
        logic                              op_mod;
        fp_format_e                        src_fmt;
        fp_format_e                        dst_fmt;
        int_format_e                       int_fmt;
        logic                              vectorial_op;
    } fpu_req_t;

    typedef struct packed {
        logic [Width-1:0] result;
        status_t          status;
    } fpu_rsp_t;

    // Requester index width; a single requester still needs a 1-bit tag.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fpnew_share_rr_sel.sv
// Rotate-priority selector: first eligible index at or after i_rr, wrapping.
module fpnew_share_rr_sel
    import fpnew_pkg::*;
#(
    parameter int unsigned NumReq   = 2,
    parameter int unsigned IdxWidth = idx_w(NumReq)
) (
    input  logic [NumReq-1:0]   i_eligible,
    input  logic [IdxWidth-1:0] i_rr,
    output logic [IdxWidth-1:0] o_sel,
    output logic                o_any
);

    logic [NumReq-1:0] w_rot;
    int unsigned       w_idx;

    always_comb begin
        o_sel = '0;
        o_any = |i_eligible;
        w_idx = 0;
        // Bit j of the rotated mask is requester (i_rr + j) mod NumReq.
        w_rot = NumReq'({i_eligible, i_eligible} >> i_rr);
        for (int j = NumReq - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_idx = 32'(i_rr) + 32'(j);
                if (w_idx >= NumReq) begin
                    w_idx = w_idx - NumReq;
                end
                o_sel = IdxWidth'(w_idx);
            end
        end
    end

endmodule

// File: rtl/fpnew_share_arbiter.sv
// Shares one FPU among NumReq requesters: round-robin issue with grant lock, tag-routed results.
// Build option FPNEW_SHARE_CREDIT_EN: per-requester in-flight credits instead of one global counter.
module fpnew_share_arbiter
    import fpnew_pkg::*;
#(
    parameter int unsigned NumReq         = 2,
    parameter int unsigned Width          = fpnew_pkg::Width,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned IdxWidth       = idx_w(NumReq)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          flush_i,
    input  fpu_req_t [NumReq-1:0]         req_i,
    input  logic     [NumReq-1:0]         req_valid_i,
    output logic     [NumReq-1:0]         req_ready_o,
    output fpu_rsp_t                      rsp_o,
    output logic     [NumReq-1:0]         rsp_valid_o,
    input  logic     [NumReq-1:0]         rsp_ready_i,
    output fpu_req_t                      fpu_req_o,
    output logic     [IdxWidth-1:0]       fpu_tag_o,
    output logic                          fpu_in_valid_o,
    input  logic                          fpu_in_ready_i,
    input  fpu_rsp_t                      fpu_rsp_i,
    input  logic     [IdxWidth-1:0]       fpu_tag_i,
    input  logic                          fpu_out_valid_i,
    output logic                          fpu_out_ready_o,
    output logic                          fpu_flush_o,
    output logic                          busy_o
);

    logic [IdxWidth-1:0] r_rr;
    logic                r_lock;
    logic [IdxWidth-1:0] r_lock_idx;

    logic [NumReq-1:0]   w_elig;
    logic [IdxWidth-1:0] w_rr_sel;
    logic [IdxWidth-1:0] w_sel;
    logic                w_any;
    logic                w_offer;
    logic                w_issue_hs;
    logic [NumReq-1:0]   w_issue_oh;
    logic                w_tag_ok;
    logic                w_retire_hs;
    logic                w_underflow;
    logic                w_busy;

    fpnew_share_rr_sel #(
        .NumReq   (NumReq),
        .IdxWidth (IdxWidth)
    ) u_rr_sel (
        .i_eligible (w_elig),
        .i_rr       (r_rr),
        .o_sel      (w_rr_sel),
        .o_any      (w_any)
    );

    // Issue side: a locked offer overrides the round-robin choice; flush masks everything.
    always_comb begin
        w_sel      = r_lock ? r_lock_idx : w_rr_sel;
        w_offer    = !flush_i && (r_lock || w_any);
        w_issue_hs = w_offer && fpu_in_ready_i;
        fpu_req_o  = req_i[0];
        w_issue_oh = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (w_sel == IdxWidth'(i)) begin
                fpu_req_o     = req_i[i];
                w_issue_oh[i] = w_issue_hs;
            end
        end
    end

    assign req_ready_o    = w_issue_oh;
    assign fpu_in_valid_o = w_offer;
    assign fpu_tag_o      = w_sel;
    assign fpu_flush_o    = flush_i;
    assign rsp_o          = fpu_rsp_i;

    // Result side: steer by returned tag; unknown tags are drained and dropped.
    always_comb begin
        w_tag_ok        = 32'(fpu_tag_i) < NumReq;
        rsp_valid_o     = '0;
        fpu_out_ready_o = !w_tag_ok;
        for (int i = 0; i < NumReq; i++) begin
            if (w_tag_ok && (fpu_tag_i == IdxWidth'(i))) begin
                rsp_valid_o[i]  = fpu_out_valid_i;
                fpu_out_ready_o = rsp_ready_i[i];
            end
        end
        w_retire_hs = fpu_out_valid_i && fpu_out_ready_o && w_tag_ok;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr       <= '0;
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
        end else if (flush_i) begin
            r_lock <= 1'b0;
        end else if (w_issue_hs) begin
            r_lock <= 1'b0;
            r_rr   <= (32'(w_sel) == NumReq - 1) ? '0 : w_sel + IdxWidth'(1);
        end else if (w_offer) begin
            r_lock     <= 1'b1;
            r_lock_idx <= w_sel;
        end
    end

`ifdef FPNEW_SHARE_CREDIT_EN
    localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);

    logic [NumReq-1:0][CntWidth-1:0] r_cnt;
    logic [NumReq-1:0]               w_retire_oh;
    logic [NumReq-1:0]               w_dec;

    always_comb begin
        w_busy      = 1'b0;
        w_underflow = 1'b0;
        for (int i = 0; i < NumReq; i++) begin
            w_elig[i]      = req_valid_i[i] && (r_cnt[i] < CntWidth'(MaxOutstanding));
            w_retire_oh[i] = w_retire_hs && (fpu_tag_i == IdxWidth'(i));
            w_dec[i]       = w_retire_oh[i] && (r_cnt[i] != '0);
            w_busy         = w_busy | (r_cnt[i] != '0);
            w_underflow    = w_underflow | (w_retire_oh[i] && (r_cnt[i] == '0));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (flush_i) begin
            r_cnt <= '0;
        end else begin
            for (int i = 0; i < NumReq; i++) begin
                if (w_issue_oh[i] && !w_dec[i]) begin
                    r_cnt[i] <= r_cnt[i] + CntWidth'(1);
                end else if (!w_issue_oh[i] && w_dec[i]) begin
                    r_cnt[i] <= r_cnt[i] - CntWidth'(1);
                end
            end
        end
    end
`else
    localparam int unsigned GCntWidth = $clog2(NumReq * MaxOutstanding + 1);

    logic [GCntWidth-1:0] r_gcnt;
    logic                 w_gdec;

    assign w_elig      = req_valid_i;
    assign w_gdec      = w_retire_hs && (r_gcnt != '0);
    assign w_underflow = w_retire_hs && (r_gcnt == '0);
    assign w_busy      = (r_gcnt != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_gcnt <= '0;
        end else if (flush_i) begin
            r_gcnt <= '0;
        end else if (w_issue_hs && !w_gdec) begin
            r_gcnt <= r_gcnt + GCntWidth'(1);
        end else if (!w_issue_hs && w_gdec) begin
            r_gcnt <= r_gcnt - GCntWidth'(1);
        end
    end
`endif

    assign busy_o = w_busy;

    a_width_match: assert property (@(posedge clk_i) Width == fpnew_pkg::Width);
    a_tag_range:   assert property (@(posedge clk_i) disable iff (!rst_ni)
                                    !(fpu_out_valid_i && !w_tag_ok));
    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !w_underflow);

endmodule
